alu_exec_unit: RTL and testbench

Execution stage directly downstream of the reservation station. It accepts at most one dispatched operation per cycle as {valid, opcode, a, b, tag} and computes the result. The result is queued in a small completion FIFO and broadcast on one common-data-bus channel as {valid, tag, value} under an external grant. Optionally, it adds a 3-stage pipelined multiplier.

---
 rtl/alu_exec_unit.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Integer execution stage that sits directly after the reservation station.
// It takes at most one dispatched operation per cycle and evaluates it.
// Results are placed in a small circular completion FIFO. The FIFO head is
// offered on one common-data-bus channel and is removed when the bus grants it.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : opcodes 17..20 (MUL, MULH, MULHSU, MULHU) go through a 3-stage
//               multiplier pipeline. The FIFO can take two pushes per edge;
//               the multiplier result is written first because it is older.
//   undefined : opcodes 17..20 complete in one cycle with result 0. There is
//               no multiplier logic and the FIFO takes one push per edge.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   rdy              run enable; when low all state holds and cdb_valid is 0
//   flush            empties the FIFO and kills in-flight multiplies
//   alu_ready        dispatch valid
//   alu_oprand       5-bit opcode
//   a, b             operands
//   alu_tag          destination tag
//   cdb_grant        bus accepted the current head this cycle
//   cdb_valid/tag/value  FIFO head, offered on the bus
//   alu_almost_full  registered, set when count >= FIFO_DEPTH-2
//   err_overflow     sticky, set when a push is dropped because the FIFO is full
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int XLEN       = 32,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic             alu_ready,
    input  logic [4:0]       alu_oprand,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] alu_tag,
    input  logic             cdb_grant,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_value,
    output logic             alu_almost_full,
    output logic             err_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL_C = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_EQ     = 5'd10,
        OP_NE     = 5'd11,
        OP_LT     = 5'd12,
        OP_GE     = 5'd13,
        OP_LTU    = 5'd14,
        OP_GEU    = 5'd15,
        OP_PASS_B = 5'd16,
        OP_MUL    = 5'd17,
        OP_MULH   = 5'd18,
        OP_MULHSU = 5'd19,
        OP_MULHU  = 5'd20
    } op_e;

    // Single-cycle result. Unknown opcodes (and multiply opcodes when the
    // multiplier is not built) fall through to 0.
    function automatic logic [XLEN-1:0] alu_calc(
        input logic [4:0]      op,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y
    );
        logic [4:0]      sh;
        logic [XLEN-1:0] r;
        sh = y[4:0];
        r  = '0;
        case (op)
            OP_ADD:    r = x + y;
            OP_SUB:    r = x - y;
            OP_SLL:    r = x << sh;
            OP_SLT:    r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU:   r = {{(XLEN-1){1'b0}}, (x < y)};
            OP_XOR:    r = x ^ y;
            OP_SRL:    r = x >> sh;
            OP_SRA:    r = $signed(x) >>> sh;
            OP_OR:     r = x | y;
            OP_AND:    r = x & y;
            OP_EQ:     r = {{(XLEN-1){1'b0}}, (x == y)};
            OP_NE:     r = {{(XLEN-1){1'b0}}, (x != y)};
            OP_LT:     r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_GE:     r = {{(XLEN-1){1'b0}}, !($signed(x) < $signed(y))};
            OP_LTU:    r = {{(XLEN-1){1'b0}}, (x < y)};
            OP_GEU:    r = {{(XLEN-1){1'b0}}, !(x < y)};
            OP_PASS_B: r = y;
            default:   r = '0;
        endcase
        return r;
    endfunction

    // FIFO storage and control state
    logic [XLEN-1:0]  val_mem_r [FIFO_DEPTH];
    logic [TAG_W-1:0] tag_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             almost_full_r;
    logic             err_overflow_r;

    logic             advance_s;
    logic             head_valid_s;
    logic             pop_s;
    logic             alu_push_s;
    logic [XLEN-1:0]  alu_result_s;
    logic [CNT_W-1:0] space_s;
    logic             alu_acc_s;
    logic             drop_s;
    logic [CNT_W-1:0] push_cnt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [PTR_W-1:0] alu_addr_s;

    // Flush overrides any same-cycle dispatch or grant.
    assign advance_s    = rdy && !flush;
    assign head_valid_s = rdy && (count_r != '0);
    assign pop_s        = advance_s && head_valid_s && cdb_grant;
    assign alu_result_s = alu_calc(alu_oprand, a, b);

`ifdef ALU_MUL_EN
    // ---------------- multiplier pipeline ----------------
    logic                is_mul_s;
    logic                a_sgn_s;
    logic                b_sgn_s;
    logic [2*XLEN-1:0]   a_ext_s;
    logic [2*XLEN-1:0]   b_ext_s;

    logic                m1_valid_r;
    logic                m1_hi_r;
    logic [TAG_W-1:0]    m1_tag_r;
    logic [2*XLEN-1:0]   m1_a_r;
    logic [2*XLEN-1:0]   m1_b_r;

    logic                m2_valid_r;
    logic                m2_hi_r;
    logic [TAG_W-1:0]    m2_tag_r;
    logic [2*XLEN-1:0]   m2_prod_r;

    logic                mul_push_s;
    logic [XLEN-1:0]     mul_val_s;
    logic                mul_acc_s;

    assign is_mul_s   = (alu_oprand >= OP_MUL) && (alu_oprand <= OP_MULHU);
    assign alu_push_s = advance_s && alu_ready && !is_mul_s;

    // Operands are sign- or zero-extended to the full product width so that
    // one unsigned multiply gives the correct low 2*XLEN bits for all variants.
    assign a_sgn_s = (alu_oprand == OP_MULH) || (alu_oprand == OP_MULHSU);
    assign b_sgn_s = (alu_oprand == OP_MULH);
    assign a_ext_s = {{XLEN{a[XLEN-1] & a_sgn_s}}, a};
    assign b_ext_s = {{XLEN{b[XLEN-1] & b_sgn_s}}, b};

    // Stage M1: capture a multiply dispatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_valid_r <= 1'b0;
            m1_hi_r    <= 1'b0;
            m1_tag_r   <= '0;
            m1_a_r     <= '0;
            m1_b_r     <= '0;
        end else if (rdy) begin
            if (flush) begin
                m1_valid_r <= 1'b0;
            end else begin
                m1_valid_r <= alu_ready && is_mul_s;
                if (alu_ready && is_mul_s) begin
                    m1_hi_r  <= (alu_oprand != OP_MUL);
                    m1_tag_r <= alu_tag;
                    m1_a_r   <= a_ext_s;
                    m1_b_r   <= b_ext_s;
                end
            end
        end
    end

    // Stage M2: form the full product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_valid_r <= 1'b0;
            m2_hi_r    <= 1'b0;
            m2_tag_r   <= '0;
            m2_prod_r  <= '0;
        end else if (rdy) begin
            if (flush) begin
                m2_valid_r <= 1'b0;
            end else begin
                m2_valid_r <= m1_valid_r;
                m2_hi_r    <= m1_hi_r;
                m2_tag_r   <= m1_tag_r;
                m2_prod_r  <= m1_a_r * m1_b_r;
            end
        end
    end

    // Stage 3 is the FIFO push of the selected product half.
    assign mul_push_s = advance_s && m2_valid_r;
    assign mul_val_s  = m2_hi_r ? m2_prod_r[2*XLEN-1:XLEN] : m2_prod_r[XLEN-1:0];

    // Admission: the older multiply result claims space first; the newer
    // single-cycle result is the one dropped if only one slot is free.
    always_comb begin
        space_s     = DEPTH_C - count_r + CNT_W'(pop_s);
        mul_acc_s   = mul_push_s && (space_s >= CNT_W'(1));
        alu_acc_s   = alu_push_s && (space_s >= (mul_acc_s ? CNT_W'(2) : CNT_W'(1)));
        drop_s      = (mul_push_s && !mul_acc_s) || (alu_push_s && !alu_acc_s);
        push_cnt_s  = CNT_W'(mul_acc_s) + CNT_W'(alu_acc_s);
        count_nxt_s = count_r + push_cnt_s - CNT_W'(pop_s);
        alu_addr_s  = wr_ptr_r + PTR_W'(mul_acc_s);
    end
`else
    assign alu_push_s = advance_s && alu_ready;

    // Admission for the single-push FIFO.
    always_comb begin
        space_s     = DEPTH_C - count_r + CNT_W'(pop_s);
        alu_acc_s   = alu_push_s && (space_s >= CNT_W'(1));
        drop_s      = alu_push_s && !alu_acc_s;
        push_cnt_s  = CNT_W'(alu_acc_s);
        count_nxt_s = count_r + push_cnt_s - CNT_W'(pop_s);
        alu_addr_s  = wr_ptr_r;
    end
`endif

    // FIFO storage writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                val_mem_r[i] <= '0;
                tag_mem_r[i] <= '0;
            end
        end else if (advance_s) begin
`ifdef ALU_MUL_EN
            if (mul_acc_s) begin
                val_mem_r[wr_ptr_r] <= mul_val_s;
                tag_mem_r[wr_ptr_r] <= m2_tag_r;
            end
`endif
            if (alu_acc_s) begin
                val_mem_r[alu_addr_s] <= alu_result_s;
                tag_mem_r[alu_addr_s] <= alu_tag;
            end
        end
    end

    // FIFO pointers, occupancy, almost-full and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r       <= '0;
            wr_ptr_r       <= '0;
            count_r        <= '0;
            almost_full_r  <= 1'b0;
            err_overflow_r <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                rd_ptr_r      <= '0;
                wr_ptr_r      <= '0;
                count_r       <= '0;
                almost_full_r <= 1'b0;
            end else begin
                rd_ptr_r      <= rd_ptr_r + PTR_W'(pop_s);
                wr_ptr_r      <= wr_ptr_r + push_cnt_s[PTR_W-1:0];
                count_r       <= count_nxt_s;
                almost_full_r <= (count_nxt_s >= AF_LVL_C);
                if (drop_s) begin
                    err_overflow_r <= 1'b1;
                end
            end
        end
    end

    // Head is offered straight from storage so a pop exposes the next entry
    // without a bubble; tag/value read as 0 whenever nothing is offered.
    assign cdb_valid       = head_valid_s;
    assign cdb_tag         = head_valid_s ? tag_mem_r[rd_ptr_r] : '0;
    assign cdb_value       = head_valid_s ? val_mem_r[rd_ptr_r] : '0;
    assign alu_almost_full = almost_full_r;
    assign err_overflow    = err_overflow_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit. Expected results come from a
// queue-based reference model and plain-arithmetic opcode semantics.
module tb_alu_exec_unit;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic        alu_ready;
    logic [4:0]  alu_oprand;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_tag;
    logic        cdb_grant;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        alu_almost_full;
    logic        err_overflow;

    alu_exec_unit #(.FIFO_DEPTH(D), .XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .alu_ready(alu_ready), .alu_oprand(alu_oprand), .a(a), .b(b),
        .alu_tag(alu_tag), .cdb_grant(cdb_grant), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_almost_full(alu_almost_full), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [3:0] tag; logic [31:0] val; } ent_t;
    typedef struct packed { logic [3:0] tag; logic [31:0] val; logic [1:0] age; } mp_t;
    ent_t exp_q[$];
    mp_t  mp_q[$];
    logic exp_af  = 1'b0;
    logic exp_err = 1'b0;

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        logic [63:0] w;
        sh = y[4:0];
        w  = {{32{x[31]}}, x} >> sh;
        case (op)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return x << sh;
            5'd3:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd4:  return (x < y) ? 32'd1 : 32'd0;
            5'd5:  return x ^ y;
            5'd6:  return x >> sh;
            5'd7:  return w[31:0];
            5'd8:  return x | y;
            5'd9:  return x & y;
            5'd10: return (x == y) ? 32'd1 : 32'd0;
            5'd11: return (x != y) ? 32'd1 : 32'd0;
            5'd12: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd13: return ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
            5'd14: return (x < y) ? 32'd1 : 32'd0;
            5'd15: return (x >= y) ? 32'd1 : 32'd0;
            5'd16: return y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          ps;
        longint unsigned pu;
        logic [63:0]     bits;
        pu = {32'd0, x} * {32'd0, y};
        case (op)
            5'd17: begin bits = pu; return bits[31:0]; end
            5'd18: begin ps = longint'($signed(x)) * longint'($signed(y)); bits = ps; return bits[63:32]; end
            5'd19: begin ps = longint'($signed(x)) * longint'({32'd0, y}); bits = ps; return bits[63:32]; end
            default: begin bits = pu; return bits[63:32]; end
        endcase
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
`ifdef ALU_MUL_EN
        return (op >= 5'd17) && (op <= 5'd20);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_push(input logic [3:0] t, input logic [31:0] v);
        if (exp_q.size() < D) exp_q.push_back('{tag: t, val: v});
        else exp_err = 1'b1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mp_q.delete();
        exp_af  = 1'b0;
        exp_err = 1'b0;
    endtask

    // Drive one cycle's inputs and let combinational outputs settle.
    task automatic set_in(input logic v, input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] t, input logic g, input logic r, input logic f);
        alu_ready = v; alu_oprand = op; a = x; b = y; alu_tag = t;
        cdb_grant = g; rdy = r; flush = f;
        #1;
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic tick();
        @(posedge clk);
        if (rdy) begin
            if (flush) begin
                exp_q.delete();
                mp_q.delete();
                exp_af = 1'b0;
            end else begin
                if (exp_q.size() > 0 && cdb_grant) void'(exp_q.pop_front());
                if (mp_q.size() > 0 && mp_q[0].age == 2'd1) begin
                    model_push(mp_q[0].tag, mp_q[0].val);
                    void'(mp_q.pop_front());
                end
                for (int i = 0; i < mp_q.size(); i++) mp_q[i].age = mp_q[i].age + 2'd1;
                if (alu_ready && is_mul_op(alu_oprand))
                    mp_q.push_back('{tag: alu_tag, val: ref_mul(alu_oprand, a, b), age: 2'd0});
                else if (alu_ready)
                    model_push(alu_tag, ref_alu(alu_oprand, a, b));
                exp_af = (exp_q.size() >= D - 2);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, g, 1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
        total++; if (cdb_tag !== 4'd0) begin bad++; $display("FAIL reset_tag: got %h want 0", cdb_tag); end
        total++; if (cdb_value !== 32'd0) begin bad++; $display("FAIL reset_value: got %h want 0", cdb_value); end
        total++; if (alu_almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b want 0", alu_almost_full); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_overflow); end
    endtask

    task automatic test_add();
        set_in(1'b1, 5'd0, 32'd7, 32'hFFFF_FFFE, 4'd3, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL add_pre_valid: got %b want 0", cdb_valid); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3 || cdb_value !== 32'd5) begin
            bad++; $display("FAIL add_head: got v=%b t=%h val=%h want v=1 t=3 val=5", cdb_valid, cdb_tag, cdb_value); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL add_after_pop: got %b want 0", cdb_valid); end
        tick();
    endtask

    task automatic test_order();
        set_in(1'b1, 5'd7, 32'h8000_0000, 32'h21, 4'd1, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b1, 5'd4, 32'd1, 32'hFFFF_FFFF, 4'd2, 1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);
            total++; if (cdb_valid !== 1'b1 || cdb_value !== 32'hC000_0000) begin
                bad++; $display("FAIL order_hold: got v=%b val=%h want v=1 val=c0000000", cdb_valid, cdb_value); end
            total++; if (alu_almost_full !== 1'b1) begin bad++; $display("FAIL order_af2: got %b want 1", alu_almost_full); end
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_tag !== 4'd1 || cdb_value !== 32'hC000_0000) begin
            bad++; $display("FAIL order_first: got t=%h val=%h want t=1 val=c0000000", cdb_tag, cdb_value); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd2 || cdb_value !== 32'd1) begin
            bad++; $display("FAIL order_second: got v=%b t=%h val=%h want v=1 t=2 val=1", cdb_valid, cdb_tag, cdb_value); end
        total++; if (alu_almost_full !== 1'b0) begin bad++; $display("FAIL order_af1: got %b want 0", alu_almost_full); end
        tick();
        idle(1, 1'b1);
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        set_in(1'b1, 5'd17, 32'hFFFF_FFFF, 32'd2, 4'd1, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL mul_early1: got %b want 0", cdb_valid); end
        tick();
        set_in(1'b1, 5'd0, 32'd1, 32'd1, 4'd2, 1'b0, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL mul_early2: got %b want 0", cdb_valid); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd1 || cdb_value !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL mul_head: got v=%b t=%h val=%h want v=1 t=1 val=fffffffe", cdb_valid, cdb_tag, cdb_value); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd2 || cdb_value !== 32'd2) begin
            bad++; $display("FAIL mul_next: got v=%b t=%h val=%h want v=1 t=2 val=2", cdb_valid, cdb_tag, cdb_value); end
        tick();
        // back-to-back multiplies of every flavour against the model
        for (int i = 0; i < 12; i++) begin
            set_in(i < 8, 5'(17 + (i % 4)), $urandom, $urandom, 4'(i), 1'b1, 1'b1, 1'b0);
            total++; if (cdb_valid !== (exp_q.size() > 0)) begin
                bad++; $display("FAIL mul_b2b_valid: got %b want %b", cdb_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                total++; if (cdb_tag !== exp_q[0].tag || cdb_value !== exp_q[0].val) begin
                    bad++; $display("FAIL mul_b2b_head: got t=%h val=%h want t=%h val=%h", cdb_tag, cdb_value, exp_q[0].tag, exp_q[0].val); end
            end
            tick();
        end
    endtask
`else
    task automatic test_mul_disabled();
        for (int i = 0; i < 5; i++) begin
            set_in(i < 4, 5'(17 + i), $urandom | 32'd3, $urandom | 32'd3, 4'(i + 8), 1'b1, 1'b1, 1'b0);
            if (i > 0) begin
                total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'(i + 7) || cdb_value !== 32'd0) begin
                    bad++; $display("FAIL muldis_head: got v=%b t=%h val=%h want v=1 t=%h val=0", cdb_valid, cdb_tag, cdb_value, 4'(i + 7)); end
            end
            tick();
        end
    endtask
`endif

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'd0, $urandom, $urandom, 4'(i), 1'b0, 1'b1, 1'b0); tick();
        end
        set_in(1'b1, 5'd17, 32'd3, 32'd5, 4'd9, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b1, 5'd0, 32'd5, 32'd5, 4'hF, 1'b1, 1'b1, 1'b1); tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
            total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: cycle %0d got %b want 0", i, cdb_valid); end
            tick();
        end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL flush_err: got %b want 0", err_overflow); end
    endtask

    task automatic test_rdy();
        logic [31:0] x0, y0, x1, y1;
        x0 = $urandom; y0 = $urandom; x1 = $urandom; y1 = $urandom;
        set_in(1'b1, 5'd5, x0, y0, 4'd4, 1'b0, 1'b1, 1'b0); tick();
        set_in(1'b1, 5'd1, x1, y1, 4'd6, 1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'd0, 32'd1, 32'd1, 4'd7, 1'b1, 1'b0, 1'b0);
            total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rdy_low_valid: got %b want 0", cdb_valid); end
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd4 || cdb_value !== (x0 ^ y0)) begin
            bad++; $display("FAIL rdy_first: got v=%b t=%h val=%h want v=1 t=4 val=%h", cdb_valid, cdb_tag, cdb_value, x0 ^ y0); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd6 || cdb_value !== (x1 - y1)) begin
            bad++; $display("FAIL rdy_second: got v=%b t=%h val=%h want v=1 t=6 val=%h", cdb_valid, cdb_tag, cdb_value, x1 - y1); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rdy_empty: got %b want 0", cdb_valid); end
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] want [5];
        logic [4:0]  op;
        logic [31:0] x, y;
        for (int k = 0; k < 5; k++) begin
            op = 5'($urandom_range(0, 16)); x = $urandom; y = $urandom;
            want[k] = ref_alu(op, x, y);
            set_in(1'b1, op, x, y, 4'(k), 1'b0, 1'b1, 1'b0);
            total++; if (alu_almost_full !== (k >= 2)) begin
                bad++; $display("FAIL ovf_af: step %0d got %b want %b", k, alu_almost_full, k >= 2); end
            total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_err_early: step %0d got %b want 0", k, err_overflow); end
            tick();
        end
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b want 1", err_overflow); end
        for (int j = 0; j < 4; j++) begin
            set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
            total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'(j) || cdb_value !== want[j]) begin
                bad++; $display("FAIL ovf_drain: entry %0d got v=%b t=%h val=%h want v=1 t=%h val=%h", j, cdb_valid, cdb_tag, cdb_value, 4'(j), want[j]); end
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b0 || err_overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_end: got v=%b err=%b want v=0 err=1", cdb_valid, err_overflow); end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'd16, 32'd0, $urandom | 32'd1, 4'(i + 1), 1'b0, 1'b1, 1'b0); tick();
        end
        set_in(1'b1, 5'd17, 32'd9, 32'd9, 4'd5, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0 || cdb_value !== 32'd0 ||
                     alu_almost_full !== 1'b0 || err_overflow !== 1'b0) begin
            bad++; $display("FAIL async_reset: got v=%b t=%h val=%h af=%b err=%b want all 0",
                            cdb_valid, cdb_tag, cdb_value, alu_almost_full, err_overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 5'd0, 32'd10, 32'd20, 4'd5, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd5 || cdb_value !== 32'd30) begin
            bad++; $display("FAIL post_reset_dispatch: got v=%b t=%h val=%h want v=1 t=5 val=1e", cdb_valid, cdb_tag, cdb_value); end
        tick();
        idle(5, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 400; i++) begin
            x = $urandom; y = ($urandom_range(0, 7) == 0) ? x : $urandom;
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 23)), x, y, 4'($urandom),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0);
            total++; if (cdb_valid !== (rdy && exp_q.size() > 0)) begin
                bad++; $display("FAIL rnd_valid: cycle %0d got %b want %b", i, cdb_valid, rdy && exp_q.size() > 0); end
            if (rdy && exp_q.size() > 0) begin
                total++; if (cdb_tag !== exp_q[0].tag || cdb_value !== exp_q[0].val) begin
                    bad++; $display("FAIL rnd_head: cycle %0d got t=%h val=%h want t=%h val=%h", i, cdb_tag, cdb_value, exp_q[0].tag, exp_q[0].val); end
            end
            total++; if (alu_almost_full !== exp_af || err_overflow !== exp_err) begin
                bad++; $display("FAIL rnd_flags: cycle %0d got af=%b err=%b want af=%b err=%b", i, alu_almost_full, err_overflow, exp_af, exp_err); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_add();
        test_order();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        idle(6, 1'b1);
        test_rdy();
        idle(6, 1'b1);
        test_flush();
        idle(6, 1'b1);
        test_overflow();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
